ex_result_pipe: RTL and testbench
=================================

Name: ex_result_pipe

Overview:
- Execute-side result staging pipe directly downstream of the ID/EX pipeline register.
- Accepts one computed 128-bit result per cycle, tagged with its destination register (0..127) and its unit latency (1..MAX_LAT).
- Delays each result until its latency expires, then presents it to the register-file write port.
- Provides a forwarding lookup and an issue-stall signal for structural and write-after-write (WAW) hazards.

Parameters:
- DATA_W, 128, result width.
- ADDR_W, 7, register address width.
- MAX_LAT, 7, deepest unit latency; number of slots.
- LAT_W, 3, latency field width; must satisfy 2^LAT_W > MAX_LAT.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous clear of all in-flight results.
- issue_valid  in  1  a result is offered this cycle.
- issue_lat  in  LAT_W  unit latency, 1..MAX_LAT.
- issue_rt  in  ADDR_W  destination register.
- issue_we  in  1  result writes the register file.
- issue_data  in  DATA_W  result value.
- issue_stall  out  1  offered result is not accepted this cycle.
- fwd_addr  in  ADDR_W  forwarding lookup address.
- fwd_hit  out  1  an in-flight writing result matches fwd_addr.
- fwd_data  out  DATA_W  matched value; 0 when no hit.
- wb_valid  out  1  slot 0 is occupied.
- wb_we  out  1  slot-0 result writes the register file.
- wb_addr  out  ADDR_W  slot-0 destination.
- wb_data  out  DATA_W  slot-0 value.

Behaviour:
- State: slots 0..MAX_LAT-1, each holding {valid, we, rt, data}. Slot 0 drives the wb_* outputs directly; there is no extra register stage.
- Every posedge (no reset, no flush):
  - slot[i] <= slot[i+1] for i < MAX_LAT-1.
  - slot[MAX_LAT-1] <= empty.
  - If the issue is accepted, the new entry is written to slot[L-1] (L = issue_lat), overriding the shifted-in value.
- Latency: a result accepted at edge k with latency L shows wb_valid=1 in the cycle after edge k+L-1. For L=1, it appears in the cycle right after the issue edge.
- issue_lat=0 is treated as 1. issue_lat>MAX_LAT is treated as MAX_LAT.
- issue_stall (combinational) = issue_valid AND (structural OR waw):
  - structural: L<MAX_LAT and slot[L].valid, i.e. the slot that would shift into L-1 is occupied.
  - waw: issue_we AND some slot j>=L with valid, we and rt==issue_rt. This guarantees same-destination results retire in issue order.
- issue_stall=0 whenever issue_valid=0. A stalled result is not captured; upstream holds and re-offers it.
- Forwarding (combinational):
  - Scan all slots for valid AND we AND rt==fwd_addr.
  - The highest-index match wins, since it is the youngest value for that register.
  - Slot 0 is included: the register file is write-before-read.
  - Entries with we=0 never match.
- wb_valid=1 with wb_we=0 indicates a non-writing completion, such as a store or branch; the register file ignores it.
- flush: all slots cleared at the edge; an issue in the same cycle is dropped. issue_stall is still computed normally from the pre-flush slots.
- reset: all slots cleared, overriding flush and issue.
- Reset value of every output is 0:
  - wb_valid, wb_we, wb_addr, wb_data are 0.
  - fwd_hit=0 and fwd_data=0 for any fwd_addr.
  - issue_stall depends only on issue_valid and empty slots, so it is 0.
- Reset mid-operation: in-flight results are lost, with no write-back.
- Throughput: one issue per cycle when there are no hazards; one write-back per cycle.

Decomposition:
- Shared package spu_pkg:
  - Constants DATA_W, ADDR_W, MAX_LAT, LAT_W.
  - typedef result_entry_t struct packed {valid, we, rt, data}.
  - These are reused by the EX/WB register and the register file.
- One sub-module, ex_fwd_select: a priority match-and-mux over MAX_LAT entries, producing fwd_hit and fwd_data.

Test Plan:
- Reset, then issue rt=5, data=0xAA..AA, lat=1 → next cycle wb_valid=1, wb_addr=5, wb_data=0xAA..AA; following cycle wb_valid=0.
- Issue rt=3 lat=4, then rt=4 lat=3 on the next cycle → issue_stall=1 on the second offer (structural). The result retires 1 cycle later than it would unstalled, and rt=3 retires first.
- Issue rt=9 lat=6, then rt=9 lat=2 the next cycle → issue_stall=1 (WAW) until rt=9/lat=6 has shifted below slot 2. The rt=9 entries retire in issue order.
- Issue rt=7 data=1 lat=5, then rt=7 data=2 lat=6 two cycles later; hold fwd_addr=7 → fwd_data=1 before the second issue, then fwd_data=2 until that result retires. fwd_hit=0 after both retire.
- Fill 3 slots, assert flush with a concurrent issue → next cycle all slots are empty, wb_valid=0, and the concurrent issue is dropped.
- Issue lat=7, then assert reset 3 cycles later → all outputs 0 the next cycle; no write-back ever appears. Also check issue_we=0: wb_we=0 and fwd_hit=0 for its rt.

Source files
------------

// File: rtl/spu_pkg.sv
// spu_pkg: shared constants and result-entry type for the execute/write-back path
package spu_pkg;

   localparam int DATA_W  = 128;
   localparam int ADDR_W  = 7;
   localparam int MAX_LAT = 7;
   localparam int LAT_W   = 3;

   typedef struct packed {
      logic              valid;
      logic              we;
      logic [ADDR_W-1:0] rt;
      logic [DATA_W-1:0] data;
   } result_entry_t;

   // Latency 0 behaves as 1; anything deeper than the pipe behaves as MAX_LAT.
   function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
      return (lat == '0) ? LAT_W'(1) : (int'(lat) > MAX_LAT) ? LAT_W'(MAX_LAT) : lat;
   endfunction

endpackage

// File: rtl/ex_fwd_select.sv
// ex_fwd_select: priority match-and-mux picking the youngest in-flight writer of addr
module ex_fwd_select
   import spu_pkg::*;
(
   input  result_entry_t       entries [MAX_LAT],
   input  logic [ADDR_W-1:0]   addr,
   output logic                hit,
   output logic [DATA_W-1:0]   data
);

   // Ascending scan so the highest-index (youngest) match overrides older ones
   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int i = 0; i < MAX_LAT; i++) begin
         if (entries[i].valid && entries[i].we && entries[i].rt == addr) begin
            hit  = 1'b1;
            data = entries[i].data;
         end
      end
   end

endmodule

// File: rtl/ex_result_pipe.sv
// ex_result_pipe: latency-aligned result staging with forwarding and hazard stall
module ex_result_pipe
   import spu_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                issue_valid,
   input  logic [LAT_W-1:0]    issue_lat,
   input  logic [ADDR_W-1:0]   issue_rt,
   input  logic                issue_we,
   input  logic [DATA_W-1:0]   issue_data,
   output logic                issue_stall,
   input  logic [ADDR_W-1:0]   fwd_addr,
   output logic                fwd_hit,
   output logic [DATA_W-1:0]   fwd_data,
   output logic                wb_valid,
   output logic                wb_we,
   output logic [ADDR_W-1:0]   wb_addr,
   output logic [DATA_W-1:0]   wb_data
);

   result_entry_t      slots [MAX_LAT];
   result_entry_t      new_entry;
   logic [LAT_W-1:0]   lat;
   logic               structural;
   logic               waw;
   logic               accept;

   assign lat       = clamp_lat(issue_lat);
   assign new_entry = '{valid: 1'b1, we: issue_we, rt: issue_rt, data: issue_data};

   // Hazards against current slots: the slot that would shift into L-1, and any
   // same-destination writer at or above L that would otherwise retire later
   always_comb begin
      structural = 1'b0;
      waw        = 1'b0;
      for (int i = 0; i < MAX_LAT; i++) begin
         if (i == int'(lat)) structural = slots[i].valid;
         if (i >= int'(lat) && slots[i].valid && slots[i].we && slots[i].rt == issue_rt) waw = 1'b1;
      end
   end

   assign issue_stall = issue_valid & (structural | (issue_we & waw));
   assign accept      = issue_valid & ~issue_stall;

   // Shift toward slot 0 each cycle; an accepted issue lands at slot L-1
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         slots <= '{default: '0};
      end else begin
         for (int i = 0; i < MAX_LAT-1; i++) slots[i] <= slots[i+1];
         slots[MAX_LAT-1] <= '0;
         if (accept) slots[lat - LAT_W'(1)] <= new_entry;
      end
   end

   ex_fwd_select u_fwd (
      .entries (slots),
      .addr    (fwd_addr),
      .hit     (fwd_hit),
      .data    (fwd_data)
   );

   assign wb_valid = slots[0].valid;
   assign wb_we    = slots[0].we;
   assign wb_addr  = slots[0].rt;
   assign wb_data  = slots[0].data;

endmodule

// File: tb/tb_ex_result_pipe.sv
// tb_ex_result_pipe: directed stimulus with a write-back scoreboard and monitor
module tb_ex_result_pipe;

   logic         clk = 1'b0;
   logic         reset, flush, issue_valid, issue_we;
   logic [2:0]   issue_lat;
   logic [6:0]   issue_rt, fwd_addr;
   logic [127:0] issue_data;
   logic         issue_stall, fwd_hit, wb_valid, wb_we;
   logic [127:0] fwd_data, wb_data;
   logic [6:0]   wb_addr;

   typedef struct {
      int           cyc;
      logic         we;
      logic [6:0]   rt;
      logic [127:0] data;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   c;

   ex_result_pipe dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .issue_valid (issue_valid),
      .issue_lat   (issue_lat),
      .issue_rt    (issue_rt),
      .issue_we    (issue_we),
      .issue_data  (issue_data),
      .issue_stall (issue_stall),
      .fwd_addr    (fwd_addr),
      .fwd_hit     (fwd_hit),
      .fwd_data    (fwd_data),
      .wb_valid    (wb_valid),
      .wb_we       (wb_we),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int ec, input logic we, input logic [6:0] rt, input logic [127:0] d);
      exp_t e;
      e.cyc = ec; e.we = we; e.rt = rt; e.data = d;
      q.push_back(e);
   endtask

   task automatic offer(input logic [2:0] lat, input logic [6:0] rt, input logic we, input logic [127:0] d);
      issue_valid = 1'b1; issue_lat = lat; issue_rt = rt; issue_we = we; issue_data = d;
   endtask

   task automatic idle();
      issue_valid = 1'b0; issue_lat = '0; issue_rt = '0; issue_we = 1'b0; issue_data = '0;
   endtask

   // Monitor: every write-back must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (wb_valid === 1'b1) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wb_unexpected: got addr %0d data %0h, required no write-back (cycle %0d)", wb_addr, wb_data, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("wb_cycle", 128'(cyc), 128'(e.cyc));
            chk("wb_we", 128'(wb_we), 128'(e.we));
            chk("wb_addr", 128'(wb_addr), 128'(e.rt));
            chk("wb_data", wb_data, e.data);
         end
      end
   end

   initial begin
      reset = 1'b1; flush = 1'b0; fwd_addr = 7'd5;
      idle();
      repeat (2) @(negedge clk);
      offer(3'd3, 7'd5, 1'b1, 128'h77);
      #1;
      chk("rst_stall", 128'(issue_stall), 0);
      chk("rst_wb_valid", 128'(wb_valid), 0);
      chk("rst_wb_we", 128'(wb_we), 0);
      chk("rst_wb_addr", 128'(wb_addr), 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_fwd_hit", 128'(fwd_hit), 0);
      chk("rst_fwd_data", fwd_data, 0);
      @(negedge clk);
      reset = 1'b0;
      idle();
      #1 chk("rst_issue_dropped", 128'(fwd_hit), 0);

      // single lat-1 result
      @(negedge clk); c = cyc;
      offer(3'd1, 7'd5, 1'b1, {16{8'hAA}});
      #1 chk("t1_stall", 128'(issue_stall), 0);
      push(c + 1, 1'b1, 7'd5, {16{8'hAA}});
      @(negedge clk); idle();
      @(negedge clk);
      #1 chk("t1_wb_clear", 128'(wb_valid), 0);

      // structural hazard
      @(negedge clk); c = cyc;
      offer(3'd4, 7'd3, 1'b1, 128'h3);
      #1 chk("t2_stall_a", 128'(issue_stall), 0);
      push(c + 4, 1'b1, 7'd3, 128'h3);
      @(negedge clk);
      offer(3'd3, 7'd4, 1'b1, 128'h4);
      #1 chk("t2_struct_stall", 128'(issue_stall), 1);
      @(negedge clk);
      #1 chk("t2_stall_release", 128'(issue_stall), 0);
      push(c + 5, 1'b1, 7'd4, 128'h4);
      @(negedge clk); idle();
      repeat (4) @(negedge clk);

      // WAW hazard
      c = cyc;
      offer(3'd6, 7'd9, 1'b1, 128'h91);
      #1 chk("t3_stall_a", 128'(issue_stall), 0);
      push(c + 6, 1'b1, 7'd9, 128'h91);
      @(negedge clk);
      offer(3'd2, 7'd9, 1'b1, 128'h92);
      for (int i = 1; i < 5; i++) begin
         #1 chk("t3_waw_stall", 128'(issue_stall), 1);
         @(negedge clk);
      end
      #1 chk("t3_waw_release", 128'(issue_stall), 0);
      push(c + 7, 1'b1, 7'd9, 128'h92);
      @(negedge clk); idle();
      repeat (4) @(negedge clk);

      // forwarding of the youngest writer
      fwd_addr = 7'd7; c = cyc;
      offer(3'd5, 7'd7, 1'b1, 128'h1);
      #1 chk("t4_stall_a", 128'(issue_stall), 0);
      chk("t4_fwd_none", 128'(fwd_hit), 0);
      push(c + 5, 1'b1, 7'd7, 128'h1);
      @(negedge clk); idle();
      #1 chk("t4_fwd_hit_old", 128'(fwd_hit), 1);
      chk("t4_fwd_data_old", fwd_data, 128'h1);
      @(negedge clk);
      offer(3'd6, 7'd7, 1'b1, 128'h2);
      #1 chk("t4_stall_b", 128'(issue_stall), 0);
      chk("t4_fwd_data_pre", fwd_data, 128'h1);
      push(c + 8, 1'b1, 7'd7, 128'h2);
      @(negedge clk); idle();
      for (int i = 3; i <= 8; i++) begin
         #1 chk("t4_fwd_hit_new", 128'(fwd_hit), 1);
         chk("t4_fwd_data_new", fwd_data, 128'h2);
         @(negedge clk);
      end
      #1 chk("t4_fwd_hit_gone", 128'(fwd_hit), 0);
      chk("t4_fwd_data_gone", fwd_data, 0);

      // flush with a concurrent issue
      @(negedge clk);
      offer(3'd5, 7'd10, 1'b1, 128'h10);
      #1 chk("t5_fill_a", 128'(issue_stall), 0);
      @(negedge clk);
      offer(3'd5, 7'd11, 1'b1, 128'h11);
      #1 chk("t5_fill_b", 128'(issue_stall), 0);
      @(negedge clk);
      offer(3'd5, 7'd12, 1'b1, 128'h12);
      #1 chk("t5_fill_c", 128'(issue_stall), 0);
      @(negedge clk);
      flush = 1'b1;
      offer(3'd4, 7'd13, 1'b1, 128'h13);
      #1 chk("t5_flush_struct_stall", 128'(issue_stall), 1);
      offer(3'd1, 7'd13, 1'b1, 128'h13);
      #1 chk("t5_flush_issue_stall", 128'(issue_stall), 0);
      @(negedge clk);
      flush = 1'b0; idle();
      #1 chk("t5_wb_valid", 128'(wb_valid), 0);
      for (int a = 10; a <= 13; a++) begin
         fwd_addr = 7'(a);
         #1 chk("t5_fwd_hit", 128'(fwd_hit), 0);
      end
      repeat (8) @(negedge clk);

      // reset mid-flight
      fwd_addr = 7'd20;
      offer(3'd7, 7'd20, 1'b1, 128'h20);
      #1 chk("t6_stall", 128'(issue_stall), 0);
      @(negedge clk); idle();
      #1 chk("t6_fwd_inflight", 128'(fwd_hit), 1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("t6_wb_valid", 128'(wb_valid), 0);
      chk("t6_wb_we", 128'(wb_we), 0);
      chk("t6_wb_addr", 128'(wb_addr), 0);
      chk("t6_wb_data", wb_data, 0);
      chk("t6_fwd_hit", 128'(fwd_hit), 0);
      chk("t6_fwd_data", fwd_data, 0);
      repeat (9) @(negedge clk);

      // non-writing completion
      fwd_addr = 7'd30; c = cyc;
      offer(3'd2, 7'd30, 1'b0, 128'h55);
      #1 chk("t7_stall", 128'(issue_stall), 0);
      push(c + 2, 1'b0, 7'd30, 128'h55);
      @(negedge clk); idle();
      #1 chk("t7_fwd_hit_slot1", 128'(fwd_hit), 0);
      @(negedge clk);
      #1 chk("t7_fwd_hit_slot0", 128'(fwd_hit), 0);
      chk("t7_wb_valid", 128'(wb_valid), 1);
      @(negedge clk);

      // back-to-back throughput
      c = cyc;
      for (int i = 0; i < 4; i++) begin
         offer(3'd1, 7'(40 + i), 1'b1, 128'(64 + i));
         #1 chk("t8_stall", 128'(issue_stall), 0);
         push(c + 1 + i, 1'b1, 7'(40 + i), 128'(64 + i));
         @(negedge clk);
      end
      idle();
      repeat (3) @(negedge clk);

      chk("sb_drained", 128'(q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
